// File: rtl/etpu_pkg.sv
// Shared types and default sizing for the edu_tpu array sequencer.
package etpu_pkg;

   // Default array dimension, activation-count width and result width
   localparam int unsigned NDef  = 4;
   localparam int unsigned KwDef = 8;
   localparam int unsigned DwDef = 16;

   // Sequencer phases, in the order a run visits them
   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StLdw,
      StFeed,
      StFlush,
      StDrain,
      StDone
   } state_e;

   // Index width for a count of n items; never narrower than one bit
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/etpu_skew_sr.sv
// Valid skew shift register: row r of the array sees the issue bit r cycles late.
module etpu_skew_sr #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         resetb,
   input  logic         clr,
   input  logic         din,
   output logic [N-1:0] q
);

   logic [N-1:0] q_d;
   logic [N-1:0] q_q;

   // Next stage values: stage 0 takes the issue bit, stage r takes stage r-1
   always_comb begin
      q_d    = '0;
      q_d[0] = din;
      for (int i = 1; i < N; i++) begin
         q_d[i] = q_q[i-1];
      end
   end

   // Shift every cycle; a cancel empties the pipeline
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         q_q <= '0;
      end else if (clr) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/etpu_seq.sv
// Sequencer for the edu_tpu NxN systolic array: clear, weight load, activation feed,
// pipeline flush and result drain over a valid/ready port.
module etpu_seq
   import etpu_pkg::*;
#(
   parameter int unsigned N  = NDef,
   parameter int unsigned KW = KwDef,
   parameter int unsigned DW = DwDef,
   localparam int unsigned SW = idx_w(N)
) (
   input  logic            clk,
   input  logic            resetb,
   input  logic            start,
   input  logic            abort,
   input  logic [KW-1:0]   k_len,
   output logic            wgt_ld,
   output logic [SW-1:0]   wgt_row,
   output logic            act_rd_en,
   output logic [KW-1:0]   act_rd_idx,
   output logic [N-1:0]    row_valid,
   output logic            en,
   output logic            arr_clr,
   output logic [N-1:0]    load_end,
   input  logic [N*DW-1:0] res_data,
   output logic [DW-1:0]   out1,
   output logic [SW-1:0]   res_sel,
   output logic            res_valid,
   input  logic            res_ready,
   output logic            dbg_active,
   output logic            done
);

   // Flush spans one buffer-latency cycle plus 2N-1 skew/propagate cycles
   localparam int unsigned FW = idx_w(2 * N);

   state_e          state_q;
   logic [KW-1:0]   k_len_q;
   logic            wgt_ld_q;
   logic [SW-1:0]   wgt_row_q;
   logic            act_rd_en_q;
   logic [KW-1:0]   act_rd_idx_q;
   logic            en_q;
   logic            arr_clr_q;
   logic [N-1:0]    load_end_q;
   logic [FW-1:0]   flush_cnt_q;
   logic [DW-1:0]   out1_q;
   logic [SW-1:0]   res_sel_q;
   logic            res_valid_q;
   logic            done_q;

   logic [DW-1:0]   col [N];
   logic [SW-1:0]   nxt_sel;
   logic            last_row;
   logic            last_act;
   logic            last_flush;
   logic            last_word;
   logic            res_fire;

   // Split the flat accumulator bus into per-column words
   always_comb begin
      for (int i = 0; i < N; i++) begin
         col[i] = res_data[i*DW +: DW];
      end
   end

   // Phase-end decodes; k_len_q is nonzero whenever FEED is active so k_len_q-1 cannot wrap
   always_comb begin
      nxt_sel    = res_sel_q + SW'(1);
      last_row   = (wgt_row_q == SW'(N - 1));
      last_act   = (act_rd_idx_q == (k_len_q - KW'(1)));
      last_flush = (flush_cnt_q == FW'(2 * N - 1));
      last_word  = (res_sel_q == SW'(N - 1));
      res_fire   = res_valid_q & res_ready;
   end

   // Sequencer FSM; every output register is set for the state being entered
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q      <= StIdle;
         k_len_q      <= '0;
         wgt_ld_q     <= 1'b0;
         wgt_row_q    <= '0;
         act_rd_en_q  <= 1'b0;
         act_rd_idx_q <= '0;
         en_q         <= 1'b0;
         arr_clr_q    <= 1'b0;
         load_end_q   <= '0;
         flush_cnt_q  <= '0;
         out1_q       <= '0;
         res_sel_q    <= '0;
         res_valid_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         arr_clr_q <= 1'b0;
         done_q    <= 1'b0;
         if (abort) begin
            // load_end is deliberately kept so debug can see how far the run got
            state_q      <= StIdle;
            wgt_ld_q     <= 1'b0;
            wgt_row_q    <= '0;
            act_rd_en_q  <= 1'b0;
            act_rd_idx_q <= '0;
            en_q         <= 1'b0;
            flush_cnt_q  <= '0;
            res_sel_q    <= '0;
            res_valid_q  <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (start) begin
                     state_q   <= StClr;
                     k_len_q   <= k_len;
                     arr_clr_q <= 1'b1;
                  end
               end
               StClr: begin
                  load_end_q <= '0;
                  if (k_len_q == '0) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= StLdw;
                     wgt_ld_q  <= 1'b1;
                     wgt_row_q <= '0;
                  end
               end
               StLdw: begin
                  load_end_q[wgt_row_q] <= 1'b1;
                  if (last_row) begin
                     state_q      <= StFeed;
                     wgt_ld_q     <= 1'b0;
                     wgt_row_q    <= '0;
                     act_rd_en_q  <= 1'b1;
                     act_rd_idx_q <= '0;
                     en_q         <= 1'b1;
                  end else begin
                     wgt_row_q <= wgt_row_q + SW'(1);
                  end
               end
               StFeed: begin
                  if (last_act) begin
                     state_q      <= StFlush;
                     act_rd_en_q  <= 1'b0;
                     act_rd_idx_q <= '0;
                     flush_cnt_q  <= '0;
                  end else begin
                     act_rd_idx_q <= act_rd_idx_q + KW'(1);
                  end
               end
               StFlush: begin
                  if (last_flush) begin
                     // Preload word 0 so it is valid on the first DRAIN cycle
                     state_q     <= StDrain;
                     en_q        <= 1'b0;
                     flush_cnt_q <= '0;
                     res_sel_q   <= '0;
                     out1_q      <= col[0];
                     res_valid_q <= 1'b1;
                  end else begin
                     flush_cnt_q <= flush_cnt_q + FW'(1);
                  end
               end
               StDrain: begin
                  if (res_fire) begin
                     if (last_word) begin
                        state_q     <= StDone;
                        res_valid_q <= 1'b0;
                        res_sel_q   <= '0;
                        done_q      <= 1'b1;
                     end else begin
                        res_sel_q <= nxt_sel;
                        out1_q    <= col[nxt_sel];
                     end
                  end
               end
               StDone: begin
                  state_q <= StIdle;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   // Row-valid skew: the issue bit is the read strobe one buffer-latency cycle later
   etpu_skew_sr #(
      .N(N)
   ) u_skew (
      .clk    (clk),
      .resetb (resetb),
      .clr    (abort),
      .din    (act_rd_en_q),
      .q      (row_valid)
   );

   assign wgt_ld     = wgt_ld_q;
   assign wgt_row    = wgt_row_q;
   assign act_rd_en  = act_rd_en_q;
   assign act_rd_idx = act_rd_idx_q;
   assign en         = en_q;
   assign arr_clr    = arr_clr_q;
   assign load_end   = load_end_q;
   assign out1       = out1_q;
   assign res_sel    = res_sel_q;
   assign res_valid  = res_valid_q;
   assign done       = done_q;
   assign dbg_active = (state_q != StIdle);

endmodule

// File: tb/tb_etpu_seq.sv
// Directed bench for etpu_seq. Inputs change and outputs are sampled on the falling edge.
module tb_etpu_seq;

   localparam int N  = 4;
   localparam int KW = 8;
   localparam int DW = 16;
   localparam int SW = 2;

   logic            clk;
   logic            resetb;
   logic            start;
   logic            abort;
   logic [KW-1:0]   k_len;
   logic            wgt_ld;
   logic [SW-1:0]   wgt_row;
   logic            act_rd_en;
   logic [KW-1:0]   act_rd_idx;
   logic [N-1:0]    row_valid;
   logic            en;
   logic            arr_clr;
   logic [N-1:0]    load_end;
   logic [N*DW-1:0] res_data;
   logic [DW-1:0]   out1;
   logic [SW-1:0]   res_sel;
   logic            res_valid;
   logic            res_ready;
   logic            dbg_active;
   logic            done;

   logic [DW-1:0]   cols [N];
   int              n_vec;
   int              n_err;

   etpu_seq dut (
      .clk        (clk),
      .resetb     (resetb),
      .start      (start),
      .abort      (abort),
      .k_len      (k_len),
      .wgt_ld     (wgt_ld),
      .wgt_row    (wgt_row),
      .act_rd_en  (act_rd_en),
      .act_rd_idx (act_rd_idx),
      .row_valid  (row_valid),
      .en         (en),
      .arr_clr    (arr_clr),
      .load_end   (load_end),
      .res_data   (res_data),
      .out1       (out1),
      .res_sel    (res_sel),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .dbg_active (dbg_active),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog expired: got no finish, want finish");
      $fatal(1);
   end

   task automatic test_reset();
      resetb = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({wgt_ld, wgt_row, act_rd_en, act_rd_idx, row_valid, en, arr_clr, load_end, out1,
           res_sel, res_valid, dbg_active, done} !== 43'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got nonzero output bus, want all 0");
      end
      resetb = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({dbg_active, done, wgt_ld, en} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_idle: got %b want 0000", {dbg_active, done, wgt_ld, en});
      end
   endtask

   // Full run checked cycle by cycle; cycle 0 is the cycle in which start is presented.
   // Phases: CLR at 1, LDW 2..N+1, FEED N+2..N+k+1, FLUSH 2N cycles, DRAIN N, DONE at 4N+k+2.
   task automatic test_run(input int k, input bit noise, input string name);
      int done_c, fd0, dr0, exp_row, exp_idx, exp_sel;
      logic [6:0] exp_ctl;
      logic [6:0] got_ctl;
      logic [N-1:0] exp_rv, exp_le;
      bit e_wld, e_rd, e_en, e_rsv;
      fd0    = 2 + N;
      dr0    = 2 + 3 * N + k;
      done_c = (k == 0) ? 2 : 2 + 4 * N + k;
      @(negedge clk);
      k_len     = KW'(k);
      res_ready = 1'b1;
      start     = 1'b1;
      for (int cyc = 1; cyc <= done_c + 2; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (noise) begin
            k_len = KW'(k + 4);
            if (cyc == fd0 + 1 || cyc == dr0 + 1) start = 1'b1;
         end
         e_wld   = (k > 0) && cyc >= 2 && cyc <= N + 1;
         e_rd    = (k > 0) && cyc >= fd0 && cyc <= N + k + 1;
         e_en    = (k > 0) && cyc >= fd0 && cyc <= 3 * N + k + 1;
         e_rsv   = (k > 0) && cyc >= dr0 && cyc <= 4 * N + k + 1;
         exp_row = cyc - 2;
         exp_idx = cyc - fd0;
         exp_sel = cyc - dr0;
         for (int r = 0; r < N; r++) begin
            exp_rv[r] = (k > 0) && cyc >= N + 3 + r && cyc <= N + k + 2 + r;
            exp_le[r] = (k > 0) && cyc >= 3 + r;
         end
         exp_ctl = {cyc == 1, e_wld, e_rd, e_en, e_rsv, cyc == done_c,
                    cyc >= 1 && cyc <= done_c};
         got_ctl = {arr_clr, wgt_ld, act_rd_en, en, res_valid, done, dbg_active};
         n_vec++;
         if (got_ctl !== exp_ctl) begin
            n_err++;
            $display("FAIL %s ctl cyc %0d: got %b want %b", name, cyc, got_ctl, exp_ctl);
         end
         n_vec++;
         if (row_valid !== exp_rv) begin
            n_err++;
            $display("FAIL %s row_valid cyc %0d: got %b want %b", name, cyc, row_valid, exp_rv);
         end
         if (cyc >= 2) begin
            n_vec++;
            if (load_end !== exp_le) begin
               n_err++;
               $display("FAIL %s load_end cyc %0d: got %b want %b", name, cyc, load_end, exp_le);
            end
         end
         if (e_wld) begin
            n_vec++;
            if (wgt_row !== SW'(exp_row)) begin
               n_err++;
               $display("FAIL %s wgt_row cyc %0d: got %0d want %0d", name, cyc, wgt_row, exp_row);
            end
         end
         if (e_rd) begin
            n_vec++;
            if (act_rd_idx !== KW'(exp_idx)) begin
               n_err++;
               $display("FAIL %s act_rd_idx cyc %0d: got %0d want %0d", name, cyc, act_rd_idx,
                        exp_idx);
            end
         end
         if (e_rsv) begin
            n_vec++;
            if (res_sel !== SW'(exp_sel) || out1 !== cols[exp_sel]) begin
               n_err++;
               $display("FAIL %s drain cyc %0d: got sel %0d data %h want sel %0d data %h", name,
                        cyc, res_sel, out1, exp_sel, cols[exp_sel]);
            end
         end
      end
      start = 1'b0;
   endtask

   // Consumer stalls with ready pattern 1,0,0,1,0,1,...; each word must hold until taken
   task automatic test_backpressure();
      int pat [8] = '{1, 0, 0, 1, 0, 1, 0, 1};
      int exp_i, step, waited;
      res_ready = 1'b0;
      @(negedge clk);
      k_len = 8'd2;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      waited = 0;
      while (res_valid !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      n_vec++;
      if (res_valid !== 1'b1) begin
         n_err++;
         $display("FAIL bp_wait_valid: got res_valid %b want 1 within 100 cycles", res_valid);
      end else begin
         exp_i = 0;
         step  = 0;
         while (exp_i < N && step < 20) begin
            n_vec++;
            if (res_valid !== 1'b1 || res_sel !== SW'(exp_i) || out1 !== cols[exp_i]) begin
               n_err++;
               $display("FAIL bp_word step %0d: got v%b sel %0d data %h want v1 sel %0d data %h",
                        step, res_valid, res_sel, out1, exp_i, cols[exp_i]);
            end
            res_ready = pat[step % 8][0];
            if (res_ready) exp_i++;
            step++;
            @(negedge clk);
         end
         n_vec++;
         if ({done, res_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL bp_done: got done,valid %b want 10", {done, res_valid});
         end
      end
      res_ready = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_abort();
      int waited, seen;
      // Abort after two weight rows are loaded
      @(negedge clk);
      k_len = 8'd8;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      waited = 0;
      while (!(wgt_ld === 1'b1 && wgt_row === 2'd2) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_vec++;
      if (load_end !== 4'b0011) begin
         n_err++;
         $display("FAIL abort_ldw_pre: got load_end %b want 0011", load_end);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_vec++;
      if ({dbg_active, wgt_ld, en, act_rd_en, load_end} !== 8'b0000_0011) begin
         n_err++;
         $display("FAIL abort_ldw: got %b want 00000011", {dbg_active, wgt_ld, en, act_rd_en,
                  load_end});
      end
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      n_vec++;
      if (seen !== 0) begin
         n_err++;
         $display("FAIL abort_no_done: got %0d done pulses want 0", seen);
      end
      // Abort in early FLUSH while the skew register still holds valids
      @(negedge clk);
      k_len = 8'd2;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      waited = 0;
      while (!(en === 1'b1 && act_rd_en === 1'b0 && row_valid !== 4'b0000) && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_vec++;
      if ({en, row_valid, act_rd_en, res_valid, dbg_active, done} !== 9'd0) begin
         n_err++;
         $display("FAIL abort_flush: got %b want 000000000", {en, row_valid, act_rd_en,
                  res_valid, dbg_active, done});
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_start_abort();
      @(negedge clk);
      k_len = 8'd4;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      n_vec++;
      if ({dbg_active, arr_clr} !== 2'b00) begin
         n_err++;
         $display("FAIL start_abort: got active,clr %b want 00", {dbg_active, arr_clr});
      end
      @(negedge clk);
      n_vec++;
      if (dbg_active !== 1'b0) begin
         n_err++;
         $display("FAIL start_abort_idle: got dbg_active %b want 0", dbg_active);
      end
   endtask

   task automatic test_reset_mid_feed();
      int waited;
      @(negedge clk);
      k_len = 8'd8;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      waited = 0;
      while (!(act_rd_en === 1'b1 && act_rd_idx === 8'd3) && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      n_vec++;
      if (act_rd_idx !== 8'd3) begin
         n_err++;
         $display("FAIL rst_feed_reach: got idx %0d want 3", act_rd_idx);
      end
      resetb = 1'b0;
      #1;
      n_vec++;
      if ({wgt_ld, wgt_row, act_rd_en, act_rd_idx, row_valid, en, arr_clr, load_end, out1,
           res_sel, res_valid, dbg_active, done} !== 43'd0) begin
         n_err++;
         $display("FAIL rst_feed_async: got en %b rv %b le %b active %b want all 0", en,
                  row_valid, load_end, dbg_active);
      end
      @(negedge clk);
      resetb = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({dbg_active, en, act_rd_en} !== 3'b000) begin
         n_err++;
         $display("FAIL rst_feed_idle: got %b want 000", {dbg_active, en, act_rd_en});
      end
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      resetb    = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      k_len     = '0;
      res_ready = 1'b1;
      cols[0]   = 16'hA5A5;
      cols[1]   = 16'hBEEF;
      cols[2]   = 16'hC0DE;
      cols[3]   = 16'h1234;
      for (int i = 0; i < N; i++) res_data[i*DW +: DW] = cols[i];

      test_reset();
      test_run(8, 1'b0, "nominal_k8");
      test_run(0, 1'b0, "k_zero");
      test_backpressure();
      test_abort();
      test_run(3, 1'b0, "after_abort_k3");
      test_run(5, 1'b1, "ignored_start_k5");
      test_start_abort();
      test_reset_mid_feed();
      test_run(1, 1'b0, "k1");
      test_run(255, 1'b0, "k_max");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
